// File: rtl/psum_norm_div.sv
// psum_norm_div: divides each signed partial-sum column by an unsigned total
// sum and emits signed 1.(bw-1) fixed-point results. A single restoring
// divider is time-shared across all columns, one quotient bit per cycle.
module psum_norm_div #(
  parameter int col     = 8,
  parameter int bw      = 8,
  parameter int bw_psum = 2*bw+4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [bw_psum*col-1:0] psum_in,
  input  logic [bw_psum+3:0]     sum_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [bw*col-1:0]      norm_out,
  output logic                   div_zero,
  output logic                   out_valid,
  input  logic                   out_ready
);

  // Dividend is |psum| shifted left by the fraction width; one quotient bit per dividend bit.
  localparam int DW  = bw_psum + bw - 1;
  localparam int RW  = bw_psum + 5;
  localparam int CW  = (col > 1) ? $clog2(col) : 1;
  localparam int BCW = $clog2(DW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  logic [bw_psum*col-1:0] psum_reg;
  logic [bw_psum+3:0]     sum_reg;
  logic [RW-1:0]          rem;
  logic [DW-1:0]          q_acc;
  logic [CW-1:0]          col_idx;
  logic [BCW-1:0]         bit_cnt;

  logic [bw_psum-1:0] cur_psum;
  logic               cur_neg;
  logic [bw_psum-1:0] cur_mag;
  logic [DW-1:0]      dividend;
  logic               first_bit;
  logic [RW-1:0]      rem_base;
  logic [RW-1:0]      trial;
  logic               take;
  logic [RW-1:0]      rem_next;
  logic [DW-1:0]      q_base;
  logic [DW-1:0]      q_next;
  logic               sat;
  logic [bw-2:0]      q_mag;
  logic [bw-1:0]      col_result;

  // One restoring-division step for the current column, plus saturation and sign
  // restore of the finished quotient. The unsigned magnitude of the most negative
  // psum wraps to exactly 2^(bw_psum-1), which is the value we want.
  always_comb begin
    cur_psum   = psum_reg[col_idx*bw_psum +: bw_psum];
    cur_neg    = cur_psum[bw_psum-1];
    cur_mag    = cur_neg ? (~cur_psum + 1'b1) : cur_psum;
    dividend   = {cur_mag, {(bw-1){1'b0}}};
    first_bit  = (bit_cnt == BCW'(DW-1));
    rem_base   = first_bit ? '0 : rem;
    trial      = {rem_base[RW-2:0], dividend[bit_cnt]};
    take       = (trial >= {1'b0, sum_reg});
    rem_next   = take ? (trial - {1'b0, sum_reg}) : trial;
    q_base     = first_bit ? '0 : q_acc;
    q_next     = {q_base[DW-2:0], take};
    sat        = |q_next[DW-1:bw-1];
    q_mag      = sat ? {(bw-1){1'b1}} : q_next[bw-2:0];
    col_result = cur_neg ? (-{1'b0, q_mag}) : {1'b0, q_mag};
  end

  // Control FSM: accepts a vector, walks every column bit-serially, then holds the result until taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      norm_out  <= '0;
      div_zero  <= 1'b0;
      psum_reg  <= '0;
      sum_reg   <= '0;
      rem       <= '0;
      q_acc     <= '0;
      col_idx   <= '0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            psum_reg <= psum_in;
            sum_reg  <= sum_in;
            in_ready <= 1'b0;
            norm_out <= '0;
            rem      <= '0;
            q_acc    <= '0;
            col_idx  <= '0;
            bit_cnt  <= BCW'(DW-1);
            if (sum_in == '0) begin
              div_zero <= 1'b1;
              state    <= DONE;
            end else begin
              div_zero <= 1'b0;
              state    <= DIV;
            end
          end
        end
        DIV: begin
          rem   <= rem_next;
          q_acc <= q_next;
          if (bit_cnt == '0) begin
            norm_out[col_idx*bw +: bw] <= col_result;
            bit_cnt <= BCW'(DW-1);
            if (col_idx == CW'(col-1)) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              col_idx <= col_idx + 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
